// File: rtl/vd_frame_ctrl.sv
// vd_frame_ctrl: frame sequencer for the Viterbi decoder. It clears the decoder,
// loads one code symbol per slot, appends zero tail slots, drains the decoder
// and collects frame_len decoded bits, compensating for the decoder latency.
module vd_frame_ctrl #(
    parameter int unsigned WD_CODE    = 2,
    parameter int unsigned SYM_CYCLES = 8,
    parameter int unsigned CLR_CYCLES = 4,
    parameter int unsigned TAIL       = 8,
    parameter int unsigned DEC_LAT    = 32,
    parameter int unsigned LEN_W      = 16
) (
    input  logic               CLOCK,
    input  logic               Reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic               sym_valid,
    input  logic [WD_CODE-1:0] sym_code,
    output logic               sym_ready,
    output logic               dec_reset_n,
    output logic               dec_active,
    output logic [WD_CODE-1:0] dec_code,
    input  logic               dec_out,
    output logic               bit_valid,
    output logic               bit_out,
    output logic               busy,
    output logic               underrun,
    output logic               done
);

    localparam int unsigned PH_W  = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
    localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);
    localparam int unsigned CNT_W = LEN_W + 7;
    localparam int unsigned EXTRA = (TAIL > DEC_LAT) ? TAIL : DEC_LAT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [CLR_W-1:0]   clr_q, clr_d;
    logic [CNT_W-1:0]   bnd_q, bnd_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [WD_CODE-1:0] code_q, code_d;
    logic               active_q, active_d;
    logic               rstn_q, rstn_d;
    logic               ready_q, ready_d;
    logic               bvalid_q, bvalid_d;
    logic               bout_q, bout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               is_bnd;
    logic [CNT_W-1:0]   j_end;

    // Next-state and registered-output logic; one boundary per symbol slot
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        clr_d    = clr_q;
        bnd_d    = bnd_q;
        len_d    = len_q;
        code_d   = code_q;
        bout_d   = bout_q;
        bvalid_d = 1'b0;
        done_d   = 1'b0;
        is_bnd   = ((state_q == S_RUN) || (state_q == S_FLUSH) || (state_q == S_DRAIN))
                   && (ph_q == PH_W'(SYM_CYCLES - 1));
        j_end    = CNT_W'(len_q) + CNT_W'(EXTRA);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = frame_len;
                    clr_d   = '0;
                    bnd_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_q == CLR_W'(CLR_CYCLES - 1)) begin
                    ph_d    = PH_W'(SYM_CYCLES - 1);
                    state_d = (len_q == '0) ? S_FLUSH : S_RUN;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            default: begin
                ph_d = is_bnd ? '0 : ph_q + 1'b1;
                if (is_bnd) begin
                    bnd_d = bnd_q + CNT_W'(1);
                    // Boundary j captures the bit of symbol j-1-DEC_LAT
                    if ((bnd_q >= CNT_W'(DEC_LAT + 1)) &&
                        (bnd_q < CNT_W'(len_q) + CNT_W'(DEC_LAT + 1))) begin
                        bvalid_d = 1'b1;
                        bout_d   = dec_out;
                    end
                    if (bnd_q == j_end) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        code_d  = '0;
                    end else if (state_q == S_RUN) begin
                        // A missing symbol still consumes its slot as a zero code
                        code_d = sym_valid ? sym_code : '0;
                        if (bnd_q + CNT_W'(1) == CNT_W'(len_q)) begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        code_d = '0;
                        if ((state_q == S_FLUSH) &&
                            (bnd_q + CNT_W'(1) >= CNT_W'(len_q) + CNT_W'(TAIL))) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
        endcase

        ready_d  = (state_d == S_RUN) && (ph_d == PH_W'(SYM_CYCLES - 1));
        active_d = ((state_d == S_RUN) || (state_d == S_FLUSH) || (state_d == S_DRAIN))
                   && (active_q || is_bnd);
        busy_d   = (state_d != S_IDLE);
        rstn_d   = (state_d != S_CLEAR);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            ph_q     <= '0;
            clr_q    <= '0;
            bnd_q    <= '0;
            len_q    <= '0;
            code_q   <= '0;
            active_q <= 1'b0;
            rstn_q   <= 1'b0;
            ready_q  <= 1'b0;
            bvalid_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            clr_q    <= clr_d;
            bnd_q    <= bnd_d;
            len_q    <= len_d;
            code_q   <= code_d;
            active_q <= active_d;
            rstn_q   <= rstn_d;
            ready_q  <= ready_d;
            bvalid_q <= bvalid_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sym_ready   = ready_q;
    assign dec_reset_n = rstn_q;
    assign dec_active  = active_q;
    assign dec_code    = code_q;
    assign bit_valid   = bvalid_q;
    assign bit_out     = bout_q;
    assign busy        = busy_q;
    assign done        = done_q;
    // Underrun flags the consuming slot itself, so it follows sym_valid directly
    assign underrun    = ready_q & ~sym_valid;

endmodule
